// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction-side fetch request path.
package ibex_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_WAIT_GNT
    } fetch_state_e;

    localparam logic [ADDR_W-1:0] FETCH_WORD_INCR = 32'd4;

endpackage

// File: rtl/ibex_instr_req_tracker.sv
// Grant-ordered queue of outstanding bus requests, each tagged with a discard bit.
// Slot 0 is always the oldest request; a response retires it and shifts the queue down.
module ibex_instr_req_tracker #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              alloc_i,
    input  logic                              alloc_discard_i,
    input  logic                              retire_i,
    input  logic                              discard_all_i,
    output logic [$clog2(NUM_REQS + 1)-1:0]   count_next_c,
    output logic                              head_discard_o,
    output logic                              any_outstanding_o
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic [NUM_REQS-1:0] free_slots;
    logic [NUM_REQS-1:0] alloc_slot;

    // Retire before allocate so a same-cycle grant lands in the slot freed by the shift.
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (retire_i) begin
            outstanding_d = outstanding_q >> 1;
            discard_d     = discard_q >> 1;
        end
        free_slots = ~outstanding_d;
        alloc_slot = free_slots & (~free_slots + NUM_REQS'(1));
        if (alloc_i) begin
            outstanding_d = outstanding_d | alloc_slot;
            discard_d     = alloc_discard_i ? (discard_d | alloc_slot) : (discard_d & ~alloc_slot);
        end
        if (discard_all_i) begin
            discard_d = discard_d | outstanding_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign count_next_c      = CNT_W'($countones(outstanding_d));
    assign head_discard_o    = discard_q[0];
    assign any_outstanding_o = |outstanding_q;

    assert property (@(posedge clk_i) disable iff (rst_i) count_next_c <= CNT_W'(NUM_REQS));

endmodule

// File: rtl/ibex_instr_req_ctrl.sv
// Instruction fetch bus initiator: issues word-aligned requests, tracks outstanding
// responses and pushes the non-discarded ones into the fetch FIFO.
module ibex_instr_req_ctrl import ibex_pkg::*; #(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [ADDR_W-1:0]   fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [ADDR_W-1:0]   instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
    localparam int unsigned SUM_W = $clog2(2 * NUM_REQS + 1);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              pend_discard_q, pend_discard_d;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic              gnt;
    logic              issue;
    logic [CNT_W-1:0]  count_next;
    logic              head_discard;
    logic              any_outstanding;

    assign gnt         = req_q & instr_gnt_i;
    assign branch_addr = {addr_i[ADDR_W-1:2], 2'b00};
    assign issue_addr  = branch_i ? branch_addr : next_addr_q;
    assign issue       = req_i & ((SUM_W'(count_next) + SUM_W'($countones(fifo_busy_i)))
                                  < SUM_W'(NUM_REQS));

    ibex_instr_req_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .alloc_i           (gnt),
        .alloc_discard_i   (pend_discard_q | branch_i),
        .retire_i          (instr_rvalid_i),
        .discard_all_i     (branch_i),
        .count_next_c      (count_next),
        .head_discard_o    (head_discard),
        .any_outstanding_o (any_outstanding)
    );

    // A branch during WAIT_GNT only updates next_addr; the held request is tagged for discard.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        addr_d         = addr_q;
        pend_discard_d = pend_discard_q;
        next_addr_d    = branch_i ? branch_addr : next_addr_q;
        case (state_q)
            FETCH_IDLE: begin
                if (issue) begin
                    state_d     = FETCH_WAIT_GNT;
                    req_d       = 1'b1;
                    addr_d      = issue_addr;
                    next_addr_d = issue_addr + FETCH_WORD_INCR;
                end
            end
            FETCH_WAIT_GNT: begin
                if (gnt) begin
                    pend_discard_d = 1'b0;
                    if (issue) begin
                        req_d       = 1'b1;
                        addr_d      = issue_addr;
                        next_addr_d = issue_addr + FETCH_WORD_INCR;
                    end else begin
                        state_d = FETCH_IDLE;
                        req_d   = 1'b0;
                    end
                end else if (branch_i) begin
                    pend_discard_d = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= FETCH_IDLE;
            req_q          <= 1'b0;
            addr_q         <= '0;
            pend_discard_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            addr_q         <= addr_d;
            pend_discard_q <= pend_discard_d;
        end
    end

    if (ResetAll) begin : g_next_addr_rst
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                next_addr_q <= '0;
            end else begin
                next_addr_q <= next_addr_d;
            end
        end
    end else begin : g_next_addr_nrst
        always_ff @(posedge clk_i) begin
            next_addr_q <= next_addr_d;
        end
    end

    assign instr_req_o  = req_q;
    assign instr_addr_o = addr_q;
    assign busy_o       = req_q | any_outstanding;

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = instr_rvalid_i & ~head_discard & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assert property (@(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> any_outstanding);
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (req_q && !instr_gnt_i) |=> $stable(addr_q));

endmodule
